// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter for the shared 3-to-8 decoded select resource.
// One owner at a time. A grant ends on done, on the owner dropping its
// request, or when the hold limit is reached. Every grant is followed by
// one GAP cycle and one IDLE decision cycle, so the decoder select never
// switches directly from one owner to another.
//
// Handshake: req[i] stays high while requester i wants or owns the
// resource. gnt/gnt_idx/gnt_valid are registered and change only on clk
// (or asynchronously on rst). done is a one-cycle strobe from the owner
// and is sampled only while gnt_valid=1. timeout pulses for one cycle,
// in the first GAP cycle after a grant is revoked by the hold limit.
module rr_decoder_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout,
  output logic [1:0] state_dbg
);

  localparam int CW = $clog2(MAX_HOLD);
  localparam logic [CW-1:0] LIMIT = CW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t        state;
  logic [2:0]    ptr;
  logic [CW-1:0] cnt;
  logic [2:0]    win;
  logic [2:0]    cand;
  logic          found;

  assign state_dbg = state;

  // First requester at or after ptr, scanning upward modulo 8.
  always_comb begin
    win   = ptr;
    cand  = ptr;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cand = ptr + 3'(k);
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  // Arbitration FSM; all outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      cnt       <= '0;
      gnt       <= 8'h00;
      gnt_idx   <= 3'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          timeout <= 1'b0;
          if (en && found) begin
            gnt       <= 8'h01 << win;
            gnt_idx   <= win;
            gnt_valid <= 1'b1;
            cnt       <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (done || !req[gnt_idx]) begin
            // Voluntary release wins over the hold limit: no timeout pulse.
            gnt       <= 8'h00;
            gnt_idx   <= 3'd0;
            gnt_valid <= 1'b0;
            ptr       <= gnt_idx + 3'd1;
            state     <= GAP;
          end else if (cnt == LIMIT) begin
            gnt       <= 8'h00;
            gnt_idx   <= 3'd0;
            gnt_valid <= 1'b0;
            ptr       <= gnt_idx + 3'd1;
            timeout   <= 1'b1;
            state     <= GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          timeout <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Bench for rr_decoder_arbiter. The driver issues grant transactions and
// pushes the expected grant (owner, length, timeout, back-to-back) into
// exp_q; the monitor watches the outputs and checks each grant window.
module tb_rr_decoder_arbiter;

  localparam int MAX_HOLD = 4;
  localparam int W = 14;  // {idx[2:0], len[8:0], tmo, b2b}

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;
  logic [1:0] state_dbg;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int mdl_ptr  = 0;
  bit contig   = 0;

  rr_decoder_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .done(done),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid),
    .timeout(timeout), .state_dbg(state_dbg)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input bit ok, input int act, input int exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference: first set bit scanning p, p+1, ... modulo 8.
  function automatic int winner(input logic [7:0] m, input int p);
    for (int k = 0; k < 8; k++) begin
      if (m[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  // kind 0: done in grant cycle d; 1: owner drops req in cycle d;
  // 2: no release, limit revokes. Called at a negedge outside a grant.
  task automatic run_grant(input logic [7:0] m, input int kind, input int d, input int en_mode);
    int w;
    int len;
    bit tmo;
    int k;
    int cyc;
    w   = winner(m, mdl_ptr);
    len = (kind == 2) ? MAX_HOLD : d;
    tmo = (kind == 2);
    exp_q.push_back({3'(w), 9'(len), tmo, contig});
    mdl_ptr = (w + 1) % 8;
    req = m;
    en  = 1'b1;
    k = 0;
    while (!gnt_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("grant_wait", gnt_valid, k, 20);
    cyc = 1;
    while (gnt_valid && cyc <= MAX_HOLD + 2) begin
      done = (kind == 0 && cyc == d);
      if (kind == 1 && cyc == d) req = m & ~(8'h01 << w);
      if (en_mode == 1) en = cyc[0];
      else if (en_mode == 2) en = 1'($urandom_range(0, 1));
      @(negedge clk);
      cyc++;
    end
    check("grant_end", !gnt_valid, int'(gnt_valid), 0);
    done   = 1'b0;
    en     = 1'b1;
    req    = m;
    contig = 1'b1;
  endtask

  // Monitor: per-cycle invariants plus per-window scoreboard compare.
  initial begin
    logic [W-1:0] cur;
    bit active;
    bit have_prev;
    int len_cnt;
    int gap;
    logic [7:0] exp_gnt;
    bit exp_tmo;
    active = 0; have_prev = 0; len_cnt = 0; gap = 0; cur = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        active = 0; have_prev = 0; gap = 0;
        continue;
      end
      exp_gnt = gnt_valid ? (8'h01 << gnt_idx) : 8'h00;
      check("gnt_onehot", gnt == exp_gnt, int'(gnt), int'(exp_gnt));
      if (!gnt_valid) check("idx_zero", gnt_idx == 3'd0, int'(gnt_idx), 0);
      exp_tmo = 1'b0;
      if (gnt_valid && !active) begin
        if (exp_q.size() == 0) begin
          check("unexpected_grant", 1'b0, int'(gnt_idx), -1);
        end else begin
          cur = exp_q.pop_front();
          check("grant_idx", gnt_idx == cur[13:11], int'(gnt_idx), int'(cur[13:11]));
          if (have_prev) begin
            if (cur[0]) check("gap_b2b", gap == 2, gap, 2);
            else check("gap_min", gap >= 2, gap, 2);
          end
        end
        active = 1; len_cnt = 1;
      end else if (gnt_valid && active) begin
        len_cnt++;
        check("idx_stable", gnt_idx == cur[13:11], int'(gnt_idx), int'(cur[13:11]));
      end else if (!gnt_valid && active) begin
        check("grant_len", len_cnt == int'(cur[10:2]), len_cnt, int'(cur[10:2]));
        exp_tmo = cur[1];
        active = 0; have_prev = 1; gap = 1;
      end else begin
        gap++;
      end
      check("timeout", timeout == exp_tmo, int'(timeout), int'(exp_tmo));
    end
  end

  // Driver: directed scenarios, then random transactions.
  initial begin
    rst = 1'b1; en = 1'b0; req = 8'h00; done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_gnt", gnt == 8'h00, int'(gnt), 0);
    check("rst_valid", gnt_valid == 1'b0, int'(gnt_valid), 0);
    check("rst_timeout", timeout == 1'b0, int'(timeout), 0);
    rst = 1'b0;
    @(negedge clk);

    // Move ptr to 3, then reset in the middle of the idx 3 grant.
    run_grant(8'h04, 0, 1, 0);
    req = 8'hFF; en = 1'b1;
    exp_q.push_back({3'd3, 9'd0, 1'b0, contig});
    for (int k = 0; k < 20 && !gnt_valid; k++) @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_gnt", gnt == 8'h00, int'(gnt), 0);
    check("async_rst_idx", gnt_idx == 3'd0, int'(gnt_idx), 0);
    check("async_rst_valid", gnt_valid == 1'b0, int'(gnt_valid), 0);
    check("async_rst_timeout", timeout == 1'b0, int'(timeout), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mdl_ptr = 0; contig = 0;
    run_grant(8'hFF, 0, 2, 0);  // first grant after reset: idx 0

    // Single requester, released on its third grant cycle, twice.
    run_grant(8'h20, 0, 3, 0);
    run_grant(8'h20, 0, 3, 0);

    // Park ptr at 0, then full rotation 0..7,0.
    run_grant(8'h80, 0, 1, 0);
    for (int i = 0; i < 9; i++) run_grant(8'hFF, 0, 1, 0);

    // Hold limit, regrant, then done coinciding with the limit.
    run_grant(8'h08, 2, 0, 0);
    run_grant(8'h08, 2, 0, 0);
    run_grant(8'h08, 0, MAX_HOLD, 0);

    // Enable gating and request drop.
    run_grant(8'h80, 0, 1, 0);
    en = 1'b0; req = 8'h81; contig = 0;
    repeat (6) @(negedge clk);
    check("en_gate", gnt_valid == 1'b0, int'(gnt_valid), 0);
    run_grant(8'h81, 1, 2, 0);  // idx 0, ends by dropping req[0]
    run_grant(8'h81, 0, 3, 1);  // idx 7, en toggled during grant

    // Random traffic.
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        req = 8'h00; contig = 0;
        en = 1'($urandom_range(0, 1));
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      run_grant(8'($urandom_range(1, 255)), $urandom_range(0, 2),
                $urandom_range(1, MAX_HOLD), $urandom_range(0, 2));
    end

    req = 8'h00;
    repeat (6) @(negedge clk);
    check("queue_drained", exp_q.size() == 0, exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
